// File: rtl/axi4lite_write_arbiter.sv
// axi4lite_write_arbiter: shares one AXI4-Lite write master (AW/W/B) between
// two valid/ready requesters, with one outstanding transaction at a time.
// Optional macro AXI4LITE_ARB_RR_EN selects round-robin arbitration;
// without it, req0 has fixed priority over req1.
//
// state  | meaning
// IDLE   | waiting for a request; grant is given combinationally this cycle
// XFER   | driving AW and W until both handshakes are done
// RESP   | m_bready high, waiting for the B response
module axi4lite_write_arbiter #(
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 32,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic [STRB_W-1:0]     req0_strb,
    output logic                  req0_ready,
    output logic                  resp0_valid,
    output logic [1:0]            resp0_resp,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic [STRB_W-1:0]     req1_strb,
    output logic                  req1_ready,
    output logic                  resp1_valid,
    output logic [1:0]            resp1_resp,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_avalid,
    input  logic                  m_aready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [STRB_W-1:0]     m_strb,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_owner;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_avalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [STRB_W-1:0]     r_m_strb;
    logic                  r_resp0_valid;
    logic                  r_resp1_valid;
    logic [1:0]            r_resp0_resp;
    logic [1:0]            r_resp1_resp;
`ifdef AXI4LITE_ARB_RR_EN
    logic                  r_last_grant;
`endif

    logic w_grant0;
    logic w_grant1;
    logic w_aw_next;
    logic w_w_next;

    // Winner selection in IDLE; ready is also held low while reset is asserted.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (rst_n && r_state == ST_IDLE) begin
`ifdef AXI4LITE_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = !r_last_grant;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
`else
            w_grant0 = req0_valid;
            w_grant1 = req1_valid && !req0_valid;
`endif
        end
    end

    assign w_aw_next = r_aw_done | (r_avalid & m_aready);
    assign w_w_next  = r_w_done  | (r_wvalid & m_ready);

    // Transaction sequencer: grant latch, AW/W handshake tracking, B capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_avalid      <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_m_addr      <= '0;
            r_m_data      <= '0;
            r_m_strb      <= '0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp0_resp  <= 2'd0;
            r_resp1_resp  <= 2'd0;
`ifdef AXI4LITE_ARB_RR_EN
            r_last_grant  <= 1'b1;
`endif
        end else begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_m_addr <= w_grant1 ? req1_addr : req0_addr;
                        r_m_data <= w_grant1 ? req1_data : req0_data;
                        r_m_strb <= w_grant1 ? req1_strb : req0_strb;
                        r_owner  <= w_grant1;
`ifdef AXI4LITE_ARB_RR_EN
                        r_last_grant <= w_grant1;
`endif
                        r_avalid <= 1'b1;
                        r_wvalid <= 1'b1;
                        r_state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_aw_next && w_w_next) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_avalid  <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_aw_done <= w_aw_next;
                        r_w_done  <= w_w_next;
                        r_avalid  <= !w_aw_next;
                        r_wvalid  <= !w_w_next;
                    end
                end
                ST_RESP: begin
                    if (m_bvalid) begin
                        r_bready <= 1'b0;
                        r_state  <= ST_IDLE;
                        if (r_owner) begin
                            r_resp1_valid <= 1'b1;
                            r_resp1_resp  <= m_bresp;
                        end else begin
                            r_resp0_valid <= 1'b1;
                            r_resp0_resp  <= m_bresp;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign resp0_valid = r_resp0_valid;
    assign resp0_resp  = r_resp0_resp;
    assign resp1_valid = r_resp1_valid;
    assign resp1_resp  = r_resp1_resp;
    assign m_addr      = r_m_addr;
    assign m_data      = r_m_data;
    assign m_strb      = r_m_strb;
    assign m_avalid    = r_avalid;
    assign m_valid     = r_wvalid;
    assign m_bready    = r_bready;

endmodule

// File: doc/axi4lite_write_arbiter.md
Name: axi4lite_write_arbiter

Overview:
Two-requester arbiter sharing one AXI4-Lite write master port (AW/W/B channels) between, e.g., the core store path (req0) and a debug/DMA writer (req1).
- Accepts simple valid/ready write requests and latches the payload on grant.
- Sequences the AW, W and B channels.
- Returns the write response to the granted requester as a one-cycle pulse.
- Only one outstanding AXI transaction at a time.

Parameters:
ADDR_WIDTH, 32, address width of requests and AXI addr
DATA_WIDTH, 32, data width; strobe width STRB_W = DATA_WIDTH/8

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 write request
req0_addr  in  ADDR_WIDTH  requester 0 address
req0_data  in  DATA_WIDTH  requester 0 write data
req0_strb  in  STRB_W  requester 0 byte strobes (0 = ignore byte)
req0_ready  out  1  grant/accept pulse for requester 0
resp0_valid  out  1  write response pulse for requester 0
resp0_resp  out  2  AXI bresp code for requester 0 (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
req1_valid, req1_addr, req1_data, req1_strb, req1_ready, resp1_valid, resp1_resp: same as requester 0, for requester 1
m_addr  out  ADDR_WIDTH  AXI write address
m_avalid  out  1  AXI address valid
m_aready  in  1  AXI address ready
m_data  out  DATA_WIDTH  AXI write data
m_strb  out  STRB_W  AXI write strobes
m_valid  out  1  AXI data valid
m_ready  in  1  AXI data ready
m_bresp  in  2  AXI write response
m_bvalid  in  1  AXI response valid
m_bready  out  1  AXI response ready

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0 (req*_ready, resp*_valid, resp*_resp, m_avalid, m_valid, m_bready, m_addr, m_data, m_strb). Internal owner=0, last_grant=1, aw_done=w_done=0.
- Reset mid-transaction: AXI outputs drop immediately; no response pulse is issued; the transaction is lost.
- IDLE:
  - If any reqN_valid, select a winner (see arbitration).
  - Assert reqN_ready for exactly that cycle, combinationally from state and valids.
  - On the clock edge: latch addr/data/strb into m_* registers, set owner=N, go to XFER.
  - Requesters hold valid and payload stable until ready; payload may change after ready.
- XFER:
  - m_avalid=!aw_done, m_valid=!w_done.
  - aw_done sets on m_avalid&m_aready; w_done sets on m_valid&m_ready. Either order or the same cycle is allowed.
  - When both handshakes are done (including same cycle), go to RESP next cycle and clear both flags.
  - First grant to m_avalid/m_valid high: 1 cycle.
- RESP:
  - m_bready=1.
  - On m_bvalid: capture m_bresp. Next cycle, resp<owner>_valid=1 for one cycle with resp<owner>_resp = captured code, and state returns to IDLE.
  - resp*_resp holds its value until the next response for that port.
- Throughput:
  - A response cycle and a new grant may coincide (IDLE).
  - Minimum 3 cycles per write when the slave is always ready (grant, XFER, RESP), with the response pulse overlapping the next grant.
- While not IDLE, req*_ready=0 regardless of req*_valid.
- m_addr/m_data/m_strb stay stable from grant until the next grant.

Optional Feature:
AXI4LITE_ARB_RR_EN
- Defined: round-robin arbitration. When both request in IDLE, grant the one != last_grant. A single requester always wins. last_grant updates on each grant.
- Undefined: fixed priority, req0 always wins over req1; last_grant is unused.

Test Plan:
1. req0 write addr=0x1000 data=0xDEADBEEF strb=0xF, slave always ready, bresp=OKAY → req0_ready pulse at cycle 0; m_avalid=m_valid=1 at cycle 1 with m_addr=0x1000; m_bready at cycle 2; resp0_valid=1 with resp0_resp=0 one cycle after the bvalid handshake; resp1_valid stays 0.
2. Split handshakes: m_aready=1 at cycle 1, m_ready delayed to cycle 4 → m_avalid drops after cycle 1; m_valid stays high through cycle 4; RESP entered at cycle 5.
3. Both requesters valid continuously, AXI4LITE_ARB_RR_EN defined → grants alternate 0,1,0,1. Undefined → req0 gets every grant while it stays valid; req1 is never granted.
4. req1 write with m_bresp=SLVERR (2) and m_bvalid delayed 5 cycles → m_bready held high throughout; resp1_valid pulse with resp1_resp=2; no req*_ready during the wait.
5. rst_n low during XFER with m_avalid=1 → m_avalid, m_valid and m_bready are 0 in the same cycle; no resp pulse; after release, a fresh req0 is granted normally.
6. Same-cycle handshake: m_aready and m_ready both 1 in the first XFER cycle with m_strb=0x3 → single-cycle XFER; m_strb=0x3 observed on the bus.
